// File: rtl/if_stage.sv
// Instruction-fetch stage: assembles each 32-bit instruction from four little-endian
// byte reads and presents it to IF/ID, honouring downstream stalls and EX redirects.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ready_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    output logic        if_valid_o
);

    typedef enum logic [2:0] {
        ST_B0  = 3'd0,
        ST_B1  = 3'd1,
        ST_B2  = 3'd2,
        ST_B3  = 3'd3,
        ST_OUT = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [23:0] r_buf;

    logic [31:0] w_byte_off;
    logic [31:0] w_target;

    // Masking keeps every target bit in use while forcing word alignment.
    assign w_target = branch_target_i & 32'hFFFF_FFFC;

    // Byte offset of the current request within the word being fetched.
    always_comb begin
        w_byte_off = 32'd0;
        case (r_state)
            ST_B0:   w_byte_off = 32'd0;
            ST_B1:   w_byte_off = 32'd1;
            ST_B2:   w_byte_off = 32'd2;
            ST_B3:   w_byte_off = 32'd3;
            ST_OUT:  w_byte_off = 32'd0;
            default: w_byte_off = 32'd0;
        endcase
    end

    assign mem_addr_o = r_pc + w_byte_off;
    assign mem_req_o  = (~rst) & (r_state != ST_OUT);

    // Fetch sequencer: byte collection, word presentation, redirect and reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= ST_B0;
            r_buf      <= 24'd0;
            if_pc_o    <= 32'd0;
            if_inst_o  <= 32'd0;
            if_valid_o <= 1'b0;
        end else if (branch_flag_i) begin
            // Redirect beats stall and any word completing this cycle.
            r_pc       <= w_target;
            r_state    <= ST_B0;
            r_buf      <= 24'd0;
            if_pc_o    <= 32'd0;
            if_inst_o  <= 32'd0;
            if_valid_o <= 1'b0;
        end else begin
            case (r_state)
                ST_B0: begin
                    if (mem_ready_i) begin
                        r_buf[7:0] <= mem_rdata_i;
                        r_state    <= ST_B1;
                    end
                end
                ST_B1: begin
                    if (mem_ready_i) begin
                        r_buf[15:8] <= mem_rdata_i;
                        r_state     <= ST_B2;
                    end
                end
                ST_B2: begin
                    if (mem_ready_i) begin
                        r_buf[23:16] <= mem_rdata_i;
                        r_state      <= ST_B3;
                    end
                end
                ST_B3: begin
                    if (mem_ready_i) begin
                        if_inst_o  <= {mem_rdata_i, r_buf};
                        if_pc_o    <= r_pc;
                        if_valid_o <= 1'b1;
                        r_pc       <= r_pc + 32'd4;
                        r_state    <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (!stall_i) begin
                        if_inst_o  <= 32'd0;
                        if_pc_o    <= 32'd0;
                        if_valid_o <= 1'b0;
                        r_state    <= ST_B0;
                    end
                end
                default: begin
                    r_state    <= ST_B0;
                    if_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
